// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, parity helper and
// the keyboard command/response bytes used around the host port.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_INHIBIT  = 3'd1,
      ST_RTS      = 3'd2,
      ST_SEND     = 3'd3,
      ST_ACK      = 3'd4,
      ST_WAIT_REL = 3'd5
   } ps2_tx_state_t;

   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
   localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge strobe,
// shareable with a system-clock receiver.
module ps2_line_sync (
   input  logic Clk,
   input  logic Rst_n,
   input  logic i_line,
   output logic o_sync,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Flops reset to 1 (idle line level) so leaving reset never fakes a fall.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= i_line;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync = r_sync;
   assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then shift the
// frame out on device clock falls and check the device's ack bit.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES        = 5000,
   parameter int START_TIMEOUT_CYCLES  = 750000,
   parameter int PACKET_TIMEOUT_CYCLES = 100000
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Key_Clk,
   input  logic       Data_in,
   output logic       Key_Clk_oe,
   output logic       Key_Data_oe,
   input  logic [7:0] Tx_data,
   input  logic       Tx_valid,
   output logic       Tx_ready,
   output logic       Tx_busy,
   output logic       Tx_done,
   output logic       Tx_err
);
   import ps2_pkg::*;

   localparam int MAX_A = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                          INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
   localparam int MAX_P = (MAX_A > PACKET_TIMEOUT_CYCLES) ? MAX_A : PACKET_TIMEOUT_CYCLES;
   localparam int CW    = $clog2(MAX_P) + 1;

   localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] PKT_LAST   = CW'(PACKET_TIMEOUT_CYCLES - 1);

   ps2_tx_state_t r_state;
   ps2_tx_state_t w_nextState;

   logic [CW-1:0] r_cnt;
   logic [3:0]    r_idx;
   logic [9:0]    r_frame;
   logic          r_clkOe;
   logic          r_dataOe;
   logic          r_ready;
   logic          r_busy;
   logic          r_done;
   logic          r_err;

   logic       w_clkSync;
   logic       w_clkFall;
   logic       w_dataSync;
   logic       w_cntClr;
   logic       w_cntInc;
   logic       w_load;
   logic [3:0] w_idxNext;
   logic       w_clkOeNext;
   logic       w_dataOeNext;
   logic       w_doneNext;
   logic       w_errNext;
   logic       w_startTo;
   logic       w_pktTo;

   ps2_line_sync u_clkSync (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .i_line (Key_Clk),
      .o_sync (w_clkSync),
      .o_fall (w_clkFall)
   );

   ps2_line_sync u_dataSync (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .i_line (Data_in),
      .o_sync (w_dataSync),
      .o_fall ()
   );

   assign w_startTo = (r_cnt >= START_LAST);
   assign w_pktTo   = (r_cnt >= PKT_LAST);

   // Outputs are registered from the next-state decision; ready stays low for
   // the pulse cycle so a held Tx_valid cannot start a frame alongside done/err.
   always_comb begin
      w_nextState  = r_state;
      w_cntClr     = 1'b0;
      w_cntInc     = 1'b0;
      w_load       = 1'b0;
      w_idxNext    = r_idx;
      w_clkOeNext  = 1'b0;
      w_dataOeNext = 1'b0;
      w_doneNext   = 1'b0;
      w_errNext    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (Tx_valid && r_ready) begin
               w_load      = 1'b1;
               w_cntClr    = 1'b1;
               w_clkOeNext = 1'b1;
               w_nextState = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            w_clkOeNext = 1'b1;
            w_cntInc    = 1'b1;
            if (r_cnt >= INH_LAST) begin
               w_dataOeNext = 1'b1;
               w_nextState  = ST_RTS;
            end
         end
         ST_RTS: begin
            w_cntClr     = 1'b1;
            w_idxNext    = 4'd0;
            w_dataOeNext = 1'b1;
            w_nextState  = ST_SEND;
         end
         ST_SEND: begin
            w_cntInc     = 1'b1;
            w_dataOeNext = r_dataOe;
            if (w_pktTo || ((r_idx == 4'd0) && w_startTo)) begin
               w_dataOeNext = 1'b0;
               w_errNext    = 1'b1;
               w_nextState  = ST_IDLE;
            end else if (w_clkFall) begin
               w_dataOeNext = ~r_frame[r_idx];
               w_idxNext    = r_idx + 4'd1;
               if (r_idx == 4'd9) begin
                  w_nextState = ST_ACK;
               end
            end
         end
         ST_ACK: begin
            w_cntInc = 1'b1;
            if (w_pktTo) begin
               w_errNext   = 1'b1;
               w_nextState = ST_IDLE;
            end else if (w_clkFall) begin
               if (!w_dataSync) begin
                  w_nextState = ST_WAIT_REL;
               end else begin
                  w_errNext   = 1'b1;
                  w_nextState = ST_IDLE;
               end
            end
         end
         ST_WAIT_REL: begin
            w_cntInc = 1'b1;
            if (w_pktTo) begin
               w_errNext   = 1'b1;
               w_nextState = ST_IDLE;
            end else if (w_clkSync && w_dataSync) begin
               w_doneNext  = 1'b1;
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state  <= ST_IDLE;
         r_idx    <= 4'd0;
         r_frame  <= 10'd0;
         r_clkOe  <= 1'b0;
         r_dataOe <= 1'b0;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_idx    <= w_idxNext;
         r_clkOe  <= w_clkOeNext;
         r_dataOe <= w_dataOeNext;
         r_ready  <= (w_nextState == ST_IDLE) && !w_doneNext && !w_errNext;
         r_busy   <= (w_nextState != ST_IDLE);
         r_done   <= w_doneNext;
         r_err    <= w_errNext;
         if (w_load) begin
            r_frame <= {1'b1, odd_parity(Tx_data), Tx_data};
         end
      end
   end

   // One counter serves inhibit length and both timeouts; it saturates.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_cnt <= '0;
      end else if (w_cntClr) begin
         r_cnt <= '0;
      end else if (w_cntInc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign Key_Clk_oe  = r_clkOe;
   assign Key_Data_oe = r_dataOe;
   assign Tx_ready    = r_ready;
   assign Tx_busy     = r_busy;
   assign Tx_done     = r_done;
   assign Tx_err      = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural open-drain PS/2 keyboard
// that clocks frames in, samples bits on rising edges and optionally acks.
module tb_ps2_host_tx;

   localparam int INH = 20;
   localparam int STO = 300;
   localparam int PTO = 2000;
   localparam int HP  = 25;

   logic       Clk = 1'b0;
   logic       Rst_n;
   logic       Key_Clk;
   logic       Data_in;
   logic       Key_Clk_oe;
   logic       Key_Data_oe;
   logic [7:0] Tx_data;
   logic       Tx_valid;
   logic       Tx_ready;
   logic       Tx_busy;
   logic       Tx_done;
   logic       Tx_err;

   logic devClk;
   logic devDataLow;

   int checks   = 0;
   int failures = 0;
   int doneCnt  = 0;
   int errCnt   = 0;

   int          n;
   int          d0;
   int          e0;
   bit          ok1;
   bit          ok2;
   logic [10:0] b1;
   logic [10:0] b2;

   ps2_host_tx #(
      .INHIBIT_CYCLES        (INH),
      .START_TIMEOUT_CYCLES  (STO),
      .PACKET_TIMEOUT_CYCLES (PTO)
   ) dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .Key_Clk     (Key_Clk),
      .Data_in     (Data_in),
      .Key_Clk_oe  (Key_Clk_oe),
      .Key_Data_oe (Key_Data_oe),
      .Tx_data     (Tx_data),
      .Tx_valid    (Tx_valid),
      .Tx_ready    (Tx_ready),
      .Tx_busy     (Tx_busy),
      .Tx_done     (Tx_done),
      .Tx_err      (Tx_err)
   );

   always #5 Clk = ~Clk;

   // Open-drain wired-AND of host and device pull-downs.
   assign Key_Clk = ~Key_Clk_oe & devClk;
   assign Data_in = ~Key_Data_oe & ~devDataLow;

   always @(negedge Clk) begin
      if (Tx_done === 1'b1) doneCnt <= doneCnt + 1;
      if (Tx_err === 1'b1)  errCnt  <= errCnt + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      @(negedge Clk);
      Tx_data  = b;
      Tx_valid = 1'b1;
      @(negedge Clk);
      Tx_valid = 1'b0;
   endtask

   task automatic waitOe(input logic level, output bit ok);
      int k = 0;
      while (Key_Clk_oe !== level && k < 200) begin
         @(negedge Clk);
         k++;
      end
      ok = (Key_Clk_oe === level);
   endtask

   // Keyboard model: the start bit is read before the first fall, then one
   // bit per rising edge; the ack is pulled low ahead of the 11th fall.
   task automatic deviceFrame(input bit doAck, input int nClk, output logic [10:0] bits,
                              output bit ok);
      bit okHi;
      bit okLo;
      bits = '0;
      waitOe(1'b1, okHi);
      waitOe(1'b0, okLo);
      ok = okHi & okLo;
      if (ok) begin
         repeat (10) @(negedge Clk);
         bits[0] = Data_in;
         for (int k = 1; k <= nClk; k++) begin
            if (k == 11) begin
               devDataLow = doAck;
               repeat (5) @(negedge Clk);
            end
            devClk = 1'b0;
            repeat (HP) @(negedge Clk);
            devClk = 1'b1;
            if (k <= 10) bits[k] = Data_in;
            if (k < nClk) repeat (HP) @(negedge Clk);
         end
         devDataLow = 1'b0;
      end
   endtask

   task automatic measureInhibit(output int len, output int both);
      len  = 0;
      both = 0;
      while (Key_Clk_oe === 1'b1 && len < 1000) begin
         len++;
         if (Key_Data_oe === 1'b1) both++;
         @(negedge Clk);
      end
   endtask

   task automatic waitResult(input string tag, output bit gotDone, output bit gotErr);
      int k = 0;
      gotDone = 1'b0;
      gotErr  = 1'b0;
      do begin
         @(negedge Clk);
         k++;
      end while (!(Tx_done === 1'b1 || Tx_err === 1'b1) && k < 4000);
      checkOutput({tag, "_result_seen"}, {31'd0, (Tx_done | Tx_err)}, 32'd1);
      if (Tx_done === 1'b1 || Tx_err === 1'b1) begin
         gotDone = Tx_done;
         gotErr  = Tx_err;
         checkOutput({tag, "_ready_in_pulse"}, {31'd0, Tx_ready}, 32'd0);
         @(negedge Clk);
         checkOutput({tag, "_ready_after"}, {31'd0, Tx_ready}, 32'd1);
      end
   endtask

   task automatic runFrame(input string tag, input logic [7:0] b, input bit doAck,
                           input logic [10:0] expBits, input bit expDone);
      logic [10:0] bits;
      bit          ok;
      bit          gd;
      bit          ge;
      int          len;
      int          both;
      int          dStart;
      int          eStart;
      dStart = doneCnt;
      eStart = errCnt;
      applyStimulus(b);
      fork
         measureInhibit(len, both);
         deviceFrame(doAck, 11, bits, ok);
         waitResult(tag, gd, ge);
      join
      repeat (5) @(negedge Clk);
      checkOutput({tag, "_dev_sync"},   {31'd0, ok}, 32'd1);
      checkOutput({tag, "_bits"},       {21'd0, bits}, {21'd0, expBits});
      checkOutput({tag, "_inhibit_len"}, len, INH + 1);
      checkOutput({tag, "_rts_cycles"}, both, 1);
      checkOutput({tag, "_done"},       {31'd0, gd}, {31'd0, expDone});
      checkOutput({tag, "_err"},        {31'd0, ge}, {31'd0, ~expDone});
      checkOutput({tag, "_done_count"}, doneCnt - dStart, expDone ? 1 : 0);
      checkOutput({tag, "_err_count"},  errCnt - eStart, expDone ? 0 : 1);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      Rst_n      = 1'b0;
      devClk     = 1'b1;
      devDataLow = 1'b0;
      Tx_valid   = 1'b0;
      Tx_data    = 8'h00;
      repeat (3) @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      checkOutput("rst_clk_oe",  {31'd0, Key_Clk_oe},  32'd0);
      checkOutput("rst_data_oe", {31'd0, Key_Data_oe}, 32'd0);
      checkOutput("rst_done",    {31'd0, Tx_done},     32'd0);
      checkOutput("rst_err",     {31'd0, Tx_err},      32'd0);
      checkOutput("rst_busy",    {31'd0, Tx_busy},     32'd0);
      checkOutput("rst_ready",   {31'd0, Tx_ready},    32'd1);

      // Expected bits {stop, parity, data[7:0], start}:
      // 0xED has six ones -> parity 1 -> 11'h7DA
      // 0xF4 has five ones -> parity 0 -> 11'h5E8
      // 0x00 has no ones   -> parity 1 -> 11'h600
      runFrame("ed", 8'hED, 1'b1, 11'h7DA, 1'b1);
      runFrame("f4", 8'hF4, 1'b1, 11'h5E8, 1'b1);
      runFrame("zero", 8'h00, 1'b1, 11'h600, 1'b1);
      runFrame("noack", 8'hED, 1'b0, 11'h7DA, 1'b0);

      // Silent device: error exactly STO cycles after the RTS exit edge.
      d0 = doneCnt;
      e0 = errCnt;
      applyStimulus(8'hED);
      waitOe(1'b1, ok1);
      waitOe(1'b0, ok2);
      checkOutput("silent_rts_exit", {31'd0, ok1 & ok2}, 32'd1);
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (Tx_err !== 1'b1 && n < STO + 50);
      checkOutput("silent_cycles",  n, STO);
      checkOutput("silent_clk_oe",  {31'd0, Key_Clk_oe},  32'd0);
      checkOutput("silent_data_oe", {31'd0, Key_Data_oe}, 32'd0);
      @(negedge Clk);
      checkOutput("silent_ready_after", {31'd0, Tx_ready}, 32'd1);
      repeat (3) @(negedge Clk);
      checkOutput("silent_err_count",  errCnt - e0, 1);
      checkOutput("silent_done_count", doneCnt - d0, 0);

      // Reset after 4 bits of 0x00: data_oe is pulling low until reset hits.
      applyStimulus(8'h00);
      deviceFrame(1'b1, 4, b1, ok1);
      checkOutput("midrst_dev_sync", {31'd0, ok1}, 32'd1);
      repeat (4) @(negedge Clk);
      checkOutput("midrst_pre_data_oe", {31'd0, Key_Data_oe}, 32'd1);
      checkOutput("midrst_pre_busy",    {31'd0, Tx_busy},     32'd1);
      #2;
      Rst_n = 1'b0;
      #1;
      checkOutput("midrst_clk_oe",  {31'd0, Key_Clk_oe},  32'd0);
      checkOutput("midrst_data_oe", {31'd0, Key_Data_oe}, 32'd0);
      checkOutput("midrst_busy",    {31'd0, Tx_busy},     32'd0);
      checkOutput("midrst_ready",   {31'd0, Tx_ready},    32'd1);
      @(negedge Clk);
      Rst_n = 1'b1;
      repeat (2) @(negedge Clk);
      runFrame("f4_after_rst", 8'hF4, 1'b1, 11'h5E8, 1'b1);

      // Back-to-back with Tx_valid held; second frame carries the new byte.
      d0 = doneCnt;
      @(negedge Clk);
      Tx_data  = 8'hF4;
      Tx_valid = 1'b1;
      fork
         begin
            deviceFrame(1'b1, 11, b1, ok1);
            deviceFrame(1'b1, 11, b2, ok2);
         end
         begin
            n = 0;
            do begin
               @(negedge Clk);
               n++;
            end while (Tx_done !== 1'b1 && n < 4000);
            checkOutput("b2b_first_done",     {31'd0, Tx_done},    32'd1);
            checkOutput("b2b_no_early_start", {31'd0, Key_Clk_oe}, 32'd0);
            Tx_data = 8'h00;
            @(negedge Clk);
            checkOutput("b2b_ready_back", {31'd0, Tx_ready},   32'd1);
            checkOutput("b2b_still_idle", {31'd0, Key_Clk_oe}, 32'd0);
            @(negedge Clk);
            checkOutput("b2b_second_accept", {31'd0, Key_Clk_oe}, 32'd1);
            Tx_valid = 1'b0;
            n = 0;
            do begin
               @(negedge Clk);
               n++;
            end while (Tx_done !== 1'b1 && n < 4000);
            checkOutput("b2b_second_done", {31'd0, Tx_done}, 32'd1);
         end
      join
      repeat (5) @(negedge Clk);
      checkOutput("b2b_dev_sync1",  {31'd0, ok1}, 32'd1);
      checkOutput("b2b_dev_sync2",  {31'd0, ok2}, 32'd1);
      checkOutput("b2b_bits1",      {21'd0, b1}, {21'd0, 11'h5E8});
      checkOutput("b2b_bits2",      {21'd0, b2}, {21'd0, 11'h600});
      checkOutput("b2b_done_count", doneCnt - d0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter for the keyboard port. It sends command bytes to the keyboard, such as 0xED (set LEDs) and 0xF4 (enable), over the same two open-drain lines the keyboard receive path listens on. Sequencing runs entirely in the system clock domain: the PS/2 clock and data lines are sampled as plain inputs, and the block drives them only through active-high pull-low enables. While `Tx_busy` is high, the receive path must ignore the line, because the device clocks this frame.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 5000: system clocks the PS/2 clock is held low before request-to-send (100 µs at 50 MHz).
- `START_TIMEOUT_CYCLES`, default 750000: maximum wait from clock release to the device's first falling edge (15 ms).
- `PACKET_TIMEOUT_CYCLES`, default 100000: maximum time from clock release to ack sampled (2 ms).

Ports:
- `Clk` in 1: system clock; the only clock in the block.
- `Rst_n` in 1: asynchronous, active-low reset.
- `Key_Clk` in 1: raw PS/2 clock line level.
- `Data_in` in 1: raw PS/2 data line level.
- `Key_Clk_oe` out 1: 1 pulls the PS/2 clock low.
- `Key_Data_oe` out 1: 1 pulls the PS/2 data low.
- `Tx_data` in 8: command byte.
- `Tx_valid` in 1: request to send `Tx_data`.
- `Tx_ready` out 1: high only in IDLE; a byte is accepted when `Tx_valid & Tx_ready`.
- `Tx_busy` out 1: high in every state except IDLE.
- `Tx_done` out 1: one-cycle pulse; the device acked the frame.
- `Tx_err` out 1: one-cycle pulse; no ack, or a timeout occurred.

## Operation
- `Key_Clk` and `Data_in` each pass through a 2-flop synchronizer. A falling edge is detected as synced previous = 1 and synced current = 0.
- On accept, the block latches `frame[9:0] = {1'b1, ~^Tx_data, Tx_data}`: stop bit, odd parity, data LSB first.
- States and transitions:
  - **IDLE**: both enables 0. On `Tx_valid`, latch the frame, clear the counter, go to INHIBIT.
  - **INHIBIT**: `Key_Clk_oe`=1. When the counter reaches `INHIBIT_CYCLES`-1, go to RTS.
  - **RTS** (exactly 1 cycle): `Key_Clk_oe`=1 and `Key_Data_oe`=1, which forms the start bit. Then go to SEND with the counter cleared and bit index 0.
  - **SEND**: `Key_Clk_oe`=0. On each falling edge, set `Key_Data_oe = ~frame[idx]` and increment idx. When the edge with idx==9 is applied (stop, so data is released), go to ACK.
  - **ACK**: on the next falling edge, sample synced data. A 0 goes to WAIT_REL; a 1 pulses `Tx_err` and goes to IDLE.
  - **WAIT_REL**: wait until synced clock and synced data are both 1, then pulse `Tx_done` and go to IDLE.
- Timeouts are counted from RTS exit:
  - No falling edge within `START_TIMEOUT_CYCLES`: error.
  - ACK not sampled within `PACKET_TIMEOUT_CYCLES`: error.
  - On error: release both lines that cycle, pulse `Tx_err`, go to IDLE.
  - WAIT_REL shares the packet timeout.
- A single counter is used, with width `$clog2(max parameter)+1`. It saturates and never wraps.
- `Tx_valid` outside IDLE is ignored; `Tx_data` is sampled only at accept.
- `Tx_done` and `Tx_err` are mutually exclusive and never asserted for the same frame.

## Timing
- Reset values: `Key_Clk_oe`=0, `Key_Data_oe`=0, `Tx_done`=0, `Tx_err`=0, `Tx_busy`=0, `Tx_ready`=1 (state IDLE).
- Reset asserted mid-frame releases both lines asynchronously, without waiting for a clock edge.
- Accept on edge N: `Key_Clk_oe`=1 from N+1.
- Clock is held low for exactly `INHIBIT_CYCLES` cycles, then 1 RTS cycle with both enables 1.
- Data change latency: 3 system cycles after the raw `Key_Clk` fall (2 sync + 1 register).
- All outputs are registered.
- Minimum frame duration: `INHIBIT_CYCLES` + 1 + 11 device clock periods + release wait.
- `Tx_ready` returns to 1 the cycle after the `Tx_done` or `Tx_err` pulse.

## Structure
- Package `ps2_pkg` holds:
  - the state enum `ps2_tx_state_t`;
  - an `odd_parity(byte)` function;
  - command constants `PS2_CMD_SET_LEDS`=8'hED, `PS2_CMD_ENABLE`=8'hF4, `PS2_CMD_RESET`=8'hFF, `PS2_RSP_ACK`=8'hFA.
- Sub-module `ps2_line_sync` (2-flop synchronizer plus falling-edge strobe, one instance per line) is reusable by a future system-clock receiver.

## Test plan
- **Normal send 0xED**: device model clocks at 12 kHz and acks. Bits seen at rising edges must be 0,1,0,1,1,0,1,1,1, parity 1, stop 1. Then exactly one `Tx_done`, and no `Tx_err`.
- **Parity 0xF4**: parity bit sampled must be 0. Also send 0x00 and check parity is 1.
- **No ack**: device leaves data high on the 11th clock. Expect one `Tx_err` and no `Tx_done`; `Tx_ready`=1 on the next cycle.
- **Device silent**: expect `Tx_err` exactly `START_TIMEOUT_CYCLES` cycles after RTS exit, with both enables 0.
- **Reset mid-SEND** (after 4 bits): `Key_Clk_oe`=`Key_Data_oe`=0 with no `Clk` edge. After release, a new 0xF4 completes normally.
- **Inhibit length and back-to-back**: measure `Key_Clk_oe` high for `INHIBIT_CYCLES`+1 cycles. Hold `Tx_valid` through a frame; a second frame must not start until after `Tx_done`, and must carry the `Tx_data` present at the second accept.
